spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- SPI mode-0 slave front end that sits directly upstream of the register file.
- Deserialises 32-bit frames from an external master and turns them into `addr`/`wdata`/`wr` register-bus transactions.
- For read frames, serialises the register file's registered `rdata` back out on MISO within the same frame.
- SPI pins are oversampled in the `clk` domain. There is no second clock.

Parameters:
- SYNC_STAGES, 2: number of flops in each input synchroniser for sclk, cs_n and mosi; minimum 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from master, asynchronous to clk
- cs_n  in  1  SPI chip select, active low, asynchronous
- mosi  in  1  SPI data from master
- miso  out  1  SPI data to master
- miso_oe  out  1  output enable for the miso pad driver
- addr  out  16  register-bus address
- wdata  out  16  register-bus write data
- wr  out  1  register-bus write strobe; single-cycle pulse
- rdata  in  16  register-bus read data; registered, valid 1 clk after addr changes
- frame_err  out  1  single-cycle pulse on an aborted or malformed frame

Behaviour:
- **Interface:** one clock, `clk`; reset `rstn` is asynchronous and active-low.
- **Reset values:** `addr`=0, `wdata`=0, `wr`=0, `miso`=0, `miso_oe`=0, `frame_err`=0, state=WAIT_IDLE, bit counter=0.
- **Input synchronisation:**
  - `sclk`, `cs_n` and `mosi` each pass through SYNC_STAGES flops plus one history flop.
  - Rising and falling `sclk` edges are detected in `clk`.
  - Master constraint: `sclk` high and low phases each ≥ SYNC_STAGES+4 clk periods.
- **Frame format**, MSB first, sampled on `sclk` rise:
  - bit31 = R/W (1 = write).
  - bits30:16 = address; `addr` = {1'b0, bits30:16}.
  - bits15:0 = data.
- **MISO timing:** driven on `sclk` falling edges.
- **State machine:**
  - WAIT_IDLE → IDLE when synced `cs_n`=1. This prevents a frame from starting mid-transfer after reset.
  - IDLE → CMD on synced `cs_n` falling; bit counter cleared. `miso_oe`=1 while `cs_n` is low in any non-WAIT_IDLE state.
  - CMD: shift `mosi` on each rise. On the 16th rise:
    - register `addr` in that cycle;
    - latch the R/W bit;
    - go to DATA.
  - DATA, read (R/W=0):
    - 2 clk after the 16th rise, load the 16-bit tx shift register from `rdata`.
    - Each falling edge from the one after the 16th rise onward drives the next tx bit on `miso`, MSB first.
  - DATA, write (R/W=1):
    - Shift `mosi` into `wdata_sh`.
    - On the 32nd rise, update `wdata` and pulse `wr` for exactly 1 clk; `addr` is stable during the pulse. Go to DONE.
  - DATA, read: on the 32nd rise, go to DONE with no bus write.
  - DONE: ignore further `sclk` edges and drive `miso`=0. → IDLE on `cs_n` rise.
  - Any state except IDLE/WAIT_IDLE, `cs_n` rise before the 32nd bit → IDLE. Pulse `frame_err` 1 clk; no `wr`.
- **`miso` / `miso_oe` outside DATA:** `miso`=0 in CMD; `miso`=0 and `miso_oe`=0 whenever synced `cs_n`=1.
- **Bus holding:** `addr` and `wdata` hold their last values between frames. `wr` is never asserted outside the DATA→DONE transition.
- **Simultaneous events:** `cs_n` rise in the same clk as the 32nd-rise detection counts as a completed frame; the write is committed.
- **Reset mid-frame:** all outputs go to reset values immediately; no partial write. The block restarts in WAIT_IDLE.

Optional Feature:
- **Macro:** `SPI_PARITY_EN`.
- **Defined:**
  - Frame is 33 bits; bit 0 (the 33rd bit) is odd parity over the 32 preceding bits.
  - A write is committed (`wdata` update + `wr` pulse) on the 33rd rise only if parity is correct. On a parity mismatch: no `wr`, `frame_err` pulses, go to DONE.
  - Read frames check parity too. A mismatch pulses `frame_err`; the read data has already been shifted out.
  - A `cs_n` rise before the 33rd bit is an abort.
- **Undefined:** 32-bit frames exactly as described in Behaviour; no parity logic is synthesised.

Test Plan:
- **Write:** frame 0x8000_0123 → `addr`=0x0000, `wdata`=0x0123, exactly one `wr` pulse after the 32nd rise; `frame_err`=0.
- **Read:** with `rdata` model returning 0x0001 for addr 1, frame 0x0001_0000 → `miso` bits 17–32 = 0x0001; `wr` never asserts; `addr`=0x0001.
- **Abort:** raise `cs_n` after 20 bits of write frame 0x8002_FFFF → no `wr`, `wdata` unchanged, one `frame_err` pulse, next frame decodes normally.
- **Over-length and back-to-back:** a 40-bit frame starting 0x8001_0001 gives exactly one `wr` (`addr`=1, `wdata`=1) and `miso`=0 after bit 32. It is followed by a read of addr 1 with `cs_n` high for the minimum time, which returns 0x0001.
- **Reset mid-frame:** assert `rstn`=0 at bit 10 with `cs_n` held low. After release, keep `cs_n` low for 8 more bits → all outputs stay at reset values and no `wr`. After `cs_n` high→low, a write of 0x8000_00AA commits correctly.
- **`SPI_PARITY_EN`:** frame 0x8000_0123 with correct parity → `wr` pulse. Same frame with inverted parity → no `wr`, one `frame_err` pulse.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 slave front end for the register file.
// Deserialises frames from an external master into addr/wdata/wr bus
// transactions and, for read frames, shifts the registered rdata back out
// on miso within the same frame. All SPI pins are oversampled in clk.
// Optional feature macro: SPI_PARITY_EN (33-bit frames, trailing odd parity).
module spi_slave_if #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic [15:0] addr,
  output logic [15:0] wdata,
  output logic        wr,
  input  logic [15:0] rdata,
  output logic        frame_err
);

`ifdef SPI_PARITY_EN
  // Index of the final rise of a frame (bit counter value before it).
  localparam logic [5:0] LAST_BIT = 6'd32;
`else
  localparam logic [5:0] LAST_BIT = 6'd31;
`endif

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    CMD       = 3'd2,
    DATA      = 3'd3,
    DONE      = 3'd4
  } state_t;

`ifdef SPI_PARITY_EN
  // Odd parity holds when the word plus its parity bit has an odd ones count.
  function automatic logic odd_par_ok(input logic [31:0] word, input logic pbit);
    return ^{word, pbit};
  endfunction
`endif

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sclk_hist_r;
  logic                   cs_hist_r;
  logic                   mosi_hist_r;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   cs_fall_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [5:0]             bit_cnt_r;
  logic [15:0]            cmd_sh_r;
  logic [15:0]            data_sh_r;
  logic [15:0]            tx_sh_r;
  logic                   rw_r;
  logic                   ld1_r;
  logic                   ld2_r;

  logic                   last_rise_s;
  logic                   addr_rise_s;
  logic                   commit_s;
  logic                   abort_s;
  logic                   par_err_s;
  logic [15:0]            data_word_s;

  logic [15:0]            addr_r;
  logic [15:0]            wdata_r;
  logic                   wr_r;
  logic                   miso_r;
  logic                   miso_oe_r;
  logic                   frame_err_r;

  // cs_n resets to 0 so a chip select held low across reset is never
  // mistaken for an idle bus; WAIT_IDLE then waits for a genuine high.
  // Synchronisers plus one history flop per SPI pin.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      mosi_sync_r <= '0;
      sclk_hist_r <= 1'b0;
      cs_hist_r   <= 1'b0;
      mosi_hist_r <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
      cs_hist_r   <= cs_sync_r[SYNC_STAGES-1];
      mosi_hist_r <= mosi_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_hist_r;
  assign rise_s      = sclk_s & ~sclk_hist_r;
  assign fall_s      = ~sclk_s & sclk_hist_r;
  assign cs_fall_s   = ~cs_s & cs_hist_r;
  assign last_rise_s = rise_s && (bit_cnt_r == LAST_BIT);
  assign addr_rise_s = rise_s && (state_r == CMD) && (bit_cnt_r == 6'd15);

`ifdef SPI_PARITY_EN
  assign data_word_s = data_sh_r;
`else
  assign data_word_s = {data_sh_r[14:0], mosi_s};
`endif

  // Next-state decode plus commit/abort/parity-error strobes.
  always_comb begin
    state_nxt_s = state_r;
    commit_s    = 1'b0;
    abort_s     = 1'b0;
    par_err_s   = 1'b0;
    case (state_r)
      WAIT_IDLE: begin
        if (cs_s) state_nxt_s = IDLE;
        else      state_nxt_s = WAIT_IDLE;
      end
      IDLE: begin
        if (cs_fall_s) state_nxt_s = CMD;
        else           state_nxt_s = IDLE;
      end
      CMD: begin
        if (cs_s) begin
          state_nxt_s = IDLE;
          abort_s     = 1'b1;
        end else if (addr_rise_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = CMD;
        end
      end
      DATA: begin
        if (last_rise_s) begin
          // A cs_n rise coinciding with the last rise still completes.
`ifdef SPI_PARITY_EN
          if (!odd_par_ok({cmd_sh_r, data_sh_r}, mosi_s)) par_err_s = 1'b1;
          else if (rw_r) commit_s = 1'b1;
          else commit_s = 1'b0;
`else
          if (rw_r) commit_s = 1'b1;
          else      commit_s = 1'b0;
`endif
          if (cs_s) state_nxt_s = IDLE;
          else      state_nxt_s = DONE;
        end else if (cs_s) begin
          state_nxt_s = IDLE;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = DATA;
        end
      end
      DONE: begin
        if (cs_s) state_nxt_s = IDLE;
        else      state_nxt_s = DONE;
      end
      default: state_nxt_s = WAIT_IDLE;
    endcase
  end

  // State register and single-cycle bus strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= WAIT_IDLE;
      wr_r        <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wr_r        <= commit_s;
      frame_err_r <= abort_s | par_err_s;
    end
  end

  // Bit counter plus command/data receive shifters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_r <= 6'd0;
      cmd_sh_r  <= 16'h0000;
      data_sh_r <= 16'h0000;
    end else begin
      if (state_r == IDLE && cs_fall_s) begin
        bit_cnt_r <= 6'd0;
      end else if (rise_s && (state_r == CMD || state_r == DATA)) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (rise_s && state_r == CMD) cmd_sh_r <= {cmd_sh_r[14:0], mosi_s};
      else                          cmd_sh_r <= cmd_sh_r;
      if (rise_s && state_r == DATA && bit_cnt_r < 6'd32) data_sh_r <= {data_sh_r[14:0], mosi_s};
      else                                                 data_sh_r <= data_sh_r;
    end
  end

  // Register-bus address/R-W capture and write data commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_r  <= 16'h0000;
      rw_r    <= 1'b0;
      wdata_r <= 16'h0000;
    end else begin
      if (addr_rise_s) begin
        addr_r <= {1'b0, cmd_sh_r[13:0], mosi_s};
        rw_r   <= cmd_sh_r[14];
      end else begin
        addr_r <= addr_r;
        rw_r   <= rw_r;
      end
      if (commit_s) wdata_r <= data_word_s;
      else          wdata_r <= wdata_r;
    end
  end

  // rdata is valid one clk after addr updates, so load the tx shifter two
  // clks after the address-completing rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ld1_r   <= 1'b0;
      ld2_r   <= 1'b0;
      tx_sh_r <= 16'h0000;
    end else begin
      ld1_r <= addr_rise_s;
      ld2_r <= ld1_r;
      if (ld2_r && !rw_r) begin
        tx_sh_r <= rdata;
      end else if (fall_s && state_r == DATA && !rw_r) begin
        tx_sh_r <= {tx_sh_r[14:0], 1'b0};
      end else begin
        tx_sh_r <= tx_sh_r;
      end
    end
  end

  // miso changes only on sclk falls during read DATA; zero elsewhere.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miso_r    <= 1'b0;
      miso_oe_r <= 1'b0;
    end else begin
      if (state_nxt_s != DATA || cs_s) begin
        miso_r <= 1'b0;
      end else if (fall_s && state_r == DATA && !rw_r) begin
        miso_r <= tx_sh_r[15];
      end else begin
        miso_r <= miso_r;
      end
      miso_oe_r <= ~cs_s && (state_nxt_s != WAIT_IDLE);
    end
  end

  assign addr      = addr_r;
  assign wdata     = wdata_r;
  assign wr        = wr_r;
  assign miso      = miso_r;
  assign miso_oe   = miso_oe_r;
  assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_if.sv
// Testbench for spi_slave_if: directed SPI frames with a queue scoreboard.
module tb_spi_slave_if;

  localparam int HALF = 80;
`ifdef SPI_PARITY_EN
  localparam int FL = 33;
`else
  localparam int FL = 32;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wr;
  logic [15:0] rdata = 16'h0000;
  logic        frame_err;

  logic [15:0] mem [4];
  logic [63:0] rx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_wr_q [$];
  logic [15:0] exp_err_q [$];
  logic [15:0] exp_rd_q [$];
  logic [15:0] rd_obs_q [$];

  spi_slave_if #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rstn(rstn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .addr(addr), .wdata(wdata), .wr(wr),
    .rdata(rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register file model: registered read, written on wr.
  always @(posedge clk) begin
    if (wr === 1'b1) mem[addr[1:0]] <= wdata;
    rdata <= mem[addr[1:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pop an expectation whenever the DUT presents a result.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (wr !== 1'b0) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_wr: got addr=%h wdata=%h expected no write", addr, wdata);
        end else begin
          check("wr_bus", {addr, wdata}, exp_wr_q.pop_front());
        end
      end
      if (frame_err !== 1'b0) begin
        if (exp_err_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_frame_err: got pulse expected none");
        end else begin
          check("err_wdata_held", {16'h0000, wdata}, {16'h0000, exp_err_q.pop_front()});
        end
      end
      if (rd_obs_q.size() > 0) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_read: got %h expected nothing", rd_obs_q.pop_front());
        end else begin
          check("miso_read", {16'h0000, rd_obs_q.pop_front()}, {16'h0000, exp_rd_q.pop_front()});
        end
      end
    end
  end

  function automatic logic [63:0] frame_bits(input logic [31:0] word);
`ifdef SPI_PARITY_EN
    return {31'd0, word, ~^word};
`else
    return {32'd0, word};
`endif
  endfunction

  task automatic shift_bits(input logic [63:0] bits, input int n, output logic [63:0] rxo);
    rxo = 64'd0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      #HALF;
      sclk = 1'b1;
      rxo = {rxo[62:0], miso};
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic cs_start();
    cs_n = 1'b0;
    #HALF;
  endtask

  task automatic cs_end(input int gap);
    #HALF;
    cs_n = 1'b1;
    #gap;
  endtask

  task automatic frame(input logic [31:0] word, input int extra, input int gap, output logic [63:0] rxo);
    cs_start();
    shift_bits(frame_bits(word) << extra, FL + extra, rxo);
    check("miso_oe_in_frame", {31'd0, miso_oe}, 32'd1);
    cs_end(gap);
    check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
  endtask

  task automatic read_frame(input logic [14:0] a, input logic [15:0] exp, input int gap);
    exp_rd_q.push_back(exp);
    frame({1'b0, a, 16'h0000}, 0, gap, rx);
    rd_obs_q.push_back(rx[FL-17 -: 16]);
    check("read_addr", {16'h0000, addr}, {17'd0, a});
  endtask

  initial begin
    mem[0] = 16'hC3A5; mem[1] = 16'h0001; mem[2] = 16'h5A3C; mem[3] = 16'h9E71;
    rstn = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    #23;
    check("rst_addr", {16'h0000, addr}, 32'd0);
    check("rst_wdata", {16'h0000, wdata}, 32'd0);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rstn = 1'b1;
    #200;

    // Write 0x8000_0123
    exp_wr_q.push_back({16'h0000, 16'h0123});
    frame(32'h8000_0123, 0, 100, rx);
    check("write_wdata", {16'h0000, wdata}, 32'h0000_0123);
    check("write_addr", {16'h0000, addr}, 32'd0);

    // Reads of addr 1 and addr 2
    read_frame(15'd1, 16'h0001, 100);
    read_frame(15'd2, 16'h5A3C, 100);

    // Abort after 20 bits of write 0x8002_FFFF
    exp_err_q.push_back(16'h0123);
    cs_start();
    shift_bits(frame_bits(32'h8002_FFFF) >> (FL - 20), 20, rx);
    cs_end(100);
    check("abort_wdata", {16'h0000, wdata}, 32'h0000_0123);
    exp_wr_q.push_back({16'h0003, 16'hBEEF});
    frame(32'h8003_BEEF, 0, 100, rx);
    check("post_abort_wdata", {16'h0000, wdata}, 32'h0000_BEEF);

    // Over-length frame, minimum cs_n gap, then read back
    exp_wr_q.push_back({16'h0001, 16'h0001});
    frame(32'h8001_0001, 8, 60, rx);
    check("overlen_miso_tail", {24'd0, rx[7:0]}, 32'd0);
    read_frame(15'd1, 16'h0001, 100);

    // Reset mid-frame with cs_n held low
    cs_start();
    shift_bits(frame_bits(32'h8000_FFFF) >> (FL - 10), 10, rx);
    rstn = 1'b0;
    #30;
    check("midrst_addr", {16'h0000, addr}, 32'd0);
    check("midrst_wdata", {16'h0000, wdata}, 32'd0);
    rstn = 1'b1;
    shift_bits(64'h0000_0000_0000_00FF, 8, rx);
    check("postrst_addr", {16'h0000, addr}, 32'd0);
    check("postrst_wdata", {16'h0000, wdata}, 32'd0);
    check("postrst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("postrst_miso", {24'd0, rx[7:0]}, 32'd0);
    cs_end(100);
    exp_wr_q.push_back({16'h0000, 16'h00AA});
    frame(32'h8000_00AA, 0, 100, rx);
    check("postrst_write", {16'h0000, wdata}, 32'h0000_00AA);

`ifdef SPI_PARITY_EN
    // Correct parity commits; inverted parity is rejected
    exp_wr_q.push_back({16'h0000, 16'h0123});
    frame(32'h8000_0123, 0, 100, rx);
    exp_err_q.push_back(16'h0123);
    cs_start();
    shift_bits(frame_bits(32'h8000_0123) ^ 64'd1, FL, rx);
    cs_end(100);
    check("par_bad_wdata", {16'h0000, wdata}, 32'h0000_0123);
`endif

    #500;
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("err_queue_drained", 32'(exp_err_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
